// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer for the registered ALU: IDLE -> EXEC -> WB with write-back.
// Define ALU_SEQ_CTRL_HAM_EN to make R-type funct 15 (HAM) a legal instruction.
module alu_seq_ctrl #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [4:0]          rf_ra,
  output logic [4:0]          rf_rb,
  output logic                b_sel,
  output logic [31:0]         imm,
  output logic [3:0]          alu_funct,
  output logic [4:0]          alu_shamt,
  output logic [4:0]          rf_wa,
  output logic                rf_we,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [3:0] FN_ADD   = 4'd1;
  localparam logic [3:0] FN_HAM   = 4'd15;

`ifdef ALU_SEQ_CTRL_HAM_EN
  localparam logic HAM_EN = 1'b1;
`else
  localparam logic HAM_EN = 1'b0;
`endif

  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; instr_ready depends on state only.

  logic [1:0]          state_q, state_d;
  logic [4:0]          ra_q, ra_d;
  logic [4:0]          rb_q, rb_d;
  logic [4:0]          wa_q, wa_d;
  logic [31:0]         imm_q, imm_d;
  logic [3:0]          funct_q, funct_d;
  logic [4:0]          shamt_q, shamt_d;
  logic                bsel_q, bsel_d;
  logic                legal_q, legal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic [5:0]  dec_opcode;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_shamt_f;
  logic [5:0]  dec_funct_f;
  logic        dec_legal;
  logic [3:0]  dec_funct;
  logic [4:0]  dec_shamt;
  logic        dec_bsel;
  logic [4:0]  dec_wa;
  logic        accept;
  logic        in_exec;
  logic        in_wb;

  assign dec_opcode  = instr[31:26];
  assign dec_rs      = instr[25:21];
  assign dec_rt      = instr[20:16];
  assign dec_rd      = instr[15:11];
  assign dec_shamt_f = instr[10:6];
  assign dec_funct_f = instr[5:0];

  // Illegal instructions latch funct 0 so EXEC makes the ALU hold its result.
  always_comb begin
    dec_legal = 1'b0;
    dec_funct = 4'd0;
    dec_shamt = 5'd0;
    dec_bsel  = 1'b0;
    dec_wa    = dec_rd;
    case (dec_opcode)
      OP_RTYPE: begin
        dec_wa = dec_rd;
        if ((dec_funct_f[5:4] == 2'b00) && (dec_funct_f[3:0] != 4'd0) &&
            (HAM_EN || (dec_funct_f[3:0] != FN_HAM))) begin
          dec_legal = 1'b1;
          dec_funct = dec_funct_f[3:0];
          dec_shamt = dec_shamt_f;
        end
      end
      OP_ADDI: begin
        dec_legal = 1'b1;
        dec_funct = FN_ADD;
        dec_shamt = 5'd0;
        dec_bsel  = 1'b1;
        dec_wa    = dec_rt;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign in_exec     = (state_q == ST_EXEC);
  assign in_wb       = (state_q == ST_WB);
  assign instr_ready = (state_q == ST_IDLE) || in_wb;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded fields are captured only on accept and otherwise hold.
  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    wa_d    = wa_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    shamt_d = shamt_q;
    bsel_d  = bsel_q;
    legal_d = legal_q;
    if (accept) begin
      ra_d    = dec_rs;
      rb_d    = dec_rt;
      wa_d    = dec_wa;
      imm_d   = {{16{instr[15]}}, instr[15:0]};
      funct_d = dec_funct;
      shamt_d = dec_shamt;
      bsel_d  = dec_bsel;
      legal_d = dec_legal;
    end
  end

  // Suppressed rd=0 writes still count as retired.
  always_comb begin
    retired_d = retired_q;
    if (in_wb && legal_q) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ra_q      <= 5'd0;
      rb_q      <= 5'd0;
      wa_q      <= 5'd0;
      imm_q     <= 32'd0;
      funct_q   <= 4'd0;
      shamt_q   <= 5'd0;
      bsel_q    <= 1'b0;
      legal_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      wa_q      <= wa_d;
      imm_q     <= imm_d;
      funct_q   <= funct_d;
      shamt_q   <= shamt_d;
      bsel_q    <= bsel_d;
      legal_q   <= legal_d;
      retired_q <= retired_d;
    end
  end

  assign rf_ra     = ra_q;
  assign rf_rb     = rb_q;
  assign rf_wa     = wa_q;
  assign imm       = imm_q;
  assign alu_funct = in_exec ? funct_q : 4'd0;
  assign alu_shamt = in_exec ? shamt_q : 5'd0;
  assign b_sel     = in_exec ? bsel_q  : 1'b0;
  assign rf_we     = in_wb && legal_q && (wa_q != 5'd0);
  assign illegal   = in_wb && !legal_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

  a_we_only_in_wb : assert property (@(posedge clk) disable iff (!rst_n)
    rf_we |-> (state_q == ST_WB));
  a_exec_goes_wb : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_EXEC) |=> (state_q == ST_WB));
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    state_q != 2'd3);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural register file and registered ALU.
module tb_alu_seq_ctrl;

  localparam int RW = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    rf_ra;
  logic [4:0]    rf_rb;
  logic          b_sel;
  logic [31:0]   imm;
  logic [3:0]    alu_funct;
  logic [4:0]    alu_shamt;
  logic [4:0]    rf_wa;
  logic          rf_we;
  logic          illegal;
  logic [RW-1:0] retired;
  logic [1:0]    dbg_state;

  int tests_run;
  int tests_failed;
  logic [RW-1:0] exp_ret;

  alu_seq_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_ra(rf_ra), .rf_rb(rf_rb), .b_sel(b_sel),
    .imm(imm), .alu_funct(alu_funct), .alu_shamt(alu_shamt), .rf_wa(rf_wa),
    .rf_we(rf_we), .illegal(illegal), .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  logic [31:0] rf_m [32];
  logic [31:0] alu_res;
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] op_a;
  logic [31:0] op_b;

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf_m[a];
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (f)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return ~(a | b);
      4'd7:  return ~b;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return $signed(a) >>> sh;
      4'd11: return a + 32'd1;
      4'd12: return a - 32'd1;
      4'd13: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd14: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd15: return 32'($countones(a));
      default: return 32'd0;
    endcase
  endfunction

  assign op_a = rf_rd(rf_ra);
  assign op_b = b_sel ? imm : rf_rd(rf_rb);

  always @(posedge clk) begin
    if (alu_funct != 4'd0) alu_res <= alu_f(alu_funct, op_a, op_b, alu_shamt);
    if (pre_we) rf_m[pre_addr] <= pre_data;
    else if (rf_we && (rf_wa != 5'd0)) rf_m[rf_wa] <= alu_res;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Presents one instruction and returns one step after the accepting edge (EXEC).
  task automatic drive_accept(input logic [31:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 8) begin
      tick();
      n++;
    end
    tests_run++;
    if (!instr_ready) begin
      tests_failed++;
      $display("FAIL accept_timeout: instr_ready=%0b required 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({instr_ready, rf_we, illegal, alu_funct, b_sel, dbg_state} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdy=%0b we=%0b ill=%0b fn=%0d bsel=%0b st=%0d required 1 0 0 0 0 0",
               instr_ready, rf_we, illegal, alu_funct, b_sel, dbg_state);
    end
    tests_run++;
    if ({retired, rf_ra, rf_rb, rf_wa, imm, alu_shamt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: ret=%0d ra=%0d rb=%0d wa=%0d imm=%h sh=%0d required all 0",
               retired, rf_ra, rf_rb, rf_wa, imm, alu_shamt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_exec();
    logic we_seen;
    we_seen = 1'b0;
    preload(5'd1, 32'd7); preload(5'd2, 32'd5); preload(5'd3, 32'h77);
    drive_accept(32'h00221801);
    tests_run++;
    if (alu_funct !== 4'd1) begin
      tests_failed++;
      $display("FAIL rst_exec_funct: got %0d required 1", alu_funct);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dbg_state, instr_ready, alu_funct} !== {2'd0, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL rst_async: st=%0d rdy=%0b fn=%0d required 0 1 0", dbg_state, instr_ready, alu_funct);
    end
    for (int i = 0; i < 2; i++) begin tick(); if (rf_we) we_seen = 1'b1; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (rf_we) we_seen = 1'b1; end
    tests_run++;
    if ({we_seen, dbg_state, retired} !== {1'b0, 2'd0, {RW{1'b0}}} || rf_m[3] !== 32'h77) begin
      tests_failed++;
      $display("FAIL rst_mid_exec: we_seen=%0b st=%0d ret=%0d r3=%h required 0 0 0 77",
               we_seen, dbg_state, retired, rf_m[3]);
    end
  endtask

  task automatic test_add();
    preload(5'd1, 32'd7); preload(5'd2, 32'd5); preload(5'd3, 32'd0);
    drive_accept(32'h00221801);
    tests_run++;
    if ({alu_funct, alu_shamt, b_sel, rf_ra, rf_rb, rf_we, instr_ready, dbg_state} !==
        {4'd1, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 2'd1}) begin
      tests_failed++;
      $display("FAIL add_exec: fn=%0d sh=%0d bsel=%0b ra=%0d rb=%0d we=%0b rdy=%0b st=%0d required 1 0 0 1 2 0 0 1",
               alu_funct, alu_shamt, b_sel, rf_ra, rf_rb, rf_we, instr_ready, dbg_state);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_wa, illegal, instr_ready, alu_funct} !== {1'b1, 5'd3, 1'b0, 1'b1, 4'd0} || alu_res !== 32'd12) begin
      tests_failed++;
      $display("FAIL add_wb: we=%0b wa=%0d ill=%0b rdy=%0b fn=%0d res=%0d required 1 3 0 1 0 12",
               rf_we, rf_wa, illegal, instr_ready, alu_funct, alu_res);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    tests_run++;
    if (rf_m[3] !== 32'd12 || retired !== exp_ret || rf_we !== 1'b0 || rf_ra !== 5'd1 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL add_commit: r3=%0d ret=%0d we=%0b ra=%0d st=%0d required 12 %0d 0 1 0",
               rf_m[3], retired, rf_we, rf_ra, dbg_state, exp_ret);
    end
  endtask

  task automatic test_sla();
    preload(5'd5, 32'd3); preload(5'd6, 32'd0);
    drive_accept(32'h00A03108);
    tests_run++;
    if ({alu_funct, alu_shamt, rf_ra, b_sel} !== {4'd8, 5'd4, 5'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL sla_exec: fn=%0d sh=%0d ra=%0d bsel=%0b required 8 4 5 0", alu_funct, alu_shamt, rf_ra, b_sel);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_wa} !== {1'b1, 5'd6} || alu_res !== 32'd48 || alu_shamt !== 5'd0) begin
      tests_failed++;
      $display("FAIL sla_wb: we=%0b wa=%0d res=%0d sh=%0d required 1 6 48 0", rf_we, rf_wa, alu_res, alu_shamt);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    tests_run++;
    if (rf_m[6] !== 32'd48 || retired !== exp_ret) begin
      tests_failed++;
      $display("FAIL sla_commit: r6=%0d ret=%0d required 48 %0d", rf_m[6], retired, exp_ret);
    end
  endtask

  task automatic test_addi();
    preload(5'd1, 32'd10); preload(5'd4, 32'd0);
    drive_accept(32'h0424FFFC);
    tests_run++;
    if ({b_sel, alu_funct, alu_shamt, rf_ra} !== {1'b1, 4'd1, 5'd0, 5'd1} || imm !== 32'hFFFFFFFC) begin
      tests_failed++;
      $display("FAIL addi_exec: bsel=%0b fn=%0d sh=%0d ra=%0d imm=%h required 1 1 0 1 fffffffc",
               b_sel, alu_funct, alu_shamt, rf_ra, imm);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_wa, b_sel} !== {1'b1, 5'd4, 1'b0} || alu_res !== 32'd6 || imm !== 32'hFFFFFFFC) begin
      tests_failed++;
      $display("FAIL addi_wb: we=%0b wa=%0d bsel=%0b res=%0d imm=%h required 1 4 0 6 fffffffc",
               rf_we, rf_wa, b_sel, alu_res, imm);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    tests_run++;
    if (rf_m[4] !== 32'd6 || retired !== exp_ret) begin
      tests_failed++;
      $display("FAIL addi_commit: r4=%0d ret=%0d required 6 %0d", rf_m[4], retired, exp_ret);
    end
  endtask

  task automatic test_back_to_back();
    preload(5'd1, 32'd7); preload(5'd2, 32'd5); preload(5'd3, 32'd0); preload(5'd4, 32'd6);
    instr = 32'h00221801;
    instr_valid = 1'b1;
    tick();
    instr = 32'h00641802;
    tests_run++;
    if ({dbg_state, instr_ready} !== {2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_exec1: st=%0d rdy=%0b required 1 0", dbg_state, instr_ready);
    end
    tick();
    tests_run++;
    if ({dbg_state, instr_ready, rf_we} !== {2'd2, 1'b1, 1'b1} || alu_res !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_wb1: st=%0d rdy=%0b we=%0b res=%0d required 2 1 1 12", dbg_state, instr_ready, rf_we, alu_res);
    end
    tick();
    instr_valid = 1'b0;
    tests_run++;
    if ({dbg_state, alu_funct, rf_ra, rf_rb} !== {2'd1, 4'd2, 5'd3, 5'd4} || rf_m[3] !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_exec2: st=%0d fn=%0d ra=%0d rb=%0d r3=%0d required 1 2 3 4 12",
               dbg_state, alu_funct, rf_ra, rf_rb, rf_m[3]);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_wa} !== {1'b1, 5'd3} || alu_res !== 32'd6) begin
      tests_failed++;
      $display("FAIL b2b_wb2: we=%0b wa=%0d res=%0d required 1 3 6", rf_we, rf_wa, alu_res);
    end
    tick();
    exp_ret = exp_ret + 2'd2;
    tests_run++;
    if (rf_m[3] !== 32'd6 || retired !== exp_ret || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL b2b_commit: r3=%0d ret=%0d st=%0d required 6 %0d 0", rf_m[3], retired, dbg_state, exp_ret);
    end
  endtask

  task automatic test_rd_zero();
    drive_accept(32'h00220001);
    tick();
    tests_run++;
    if ({rf_we, illegal, rf_wa} !== {1'b0, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL rd0_wb: we=%0b ill=%0b wa=%0d required 0 0 0", rf_we, illegal, rf_wa);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    tests_run++;
    if (retired !== exp_ret) begin
      tests_failed++;
      $display("FAIL rd0_retired: got %0d required %0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] vec [3];
    logic [31:0] held;
    vec[0] = 32'h08221801;
    vec[1] = 32'h00221810;
    vec[2] = 32'h00221800;
    preload(5'd3, 32'h55);
    for (int i = 0; i < 3; i++) begin
      held = alu_res;
      drive_accept(vec[i]);
      tests_run++;
      if ({alu_funct, alu_shamt, b_sel, illegal} !== {4'd0, 5'd0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL illegal_exec[%0d]: fn=%0d sh=%0d bsel=%0b ill=%0b required 0 0 0 0",
                 i, alu_funct, alu_shamt, b_sel, illegal);
      end
      tick();
      tests_run++;
      if ({illegal, rf_we} !== {1'b1, 1'b0} || alu_res !== held) begin
        tests_failed++;
        $display("FAIL illegal_wb[%0d]: ill=%0b we=%0b res=%h required 1 0 %h", i, illegal, rf_we, alu_res, held);
      end
      tick();
      tests_run++;
      if (retired !== exp_ret || illegal !== 1'b0 || rf_m[3] !== 32'h55) begin
        tests_failed++;
        $display("FAIL illegal_after[%0d]: ret=%0d ill=%0b r3=%h required %0d 0 55", i, retired, illegal, rf_m[3], exp_ret);
      end
    end
  endtask

  task automatic test_ham();
    preload(5'd1, 32'hF0F0F0F0); preload(5'd3, 32'h55);
    drive_accept(32'h0022180F);
`ifdef ALU_SEQ_CTRL_HAM_EN
    tests_run++;
    if (alu_funct !== 4'd15) begin
      tests_failed++;
      $display("FAIL ham_exec: fn=%0d required 15", alu_funct);
    end
    tick();
    tests_run++;
    if ({rf_we, illegal} !== {1'b1, 1'b0} || alu_res !== 32'd16) begin
      tests_failed++;
      $display("FAIL ham_wb: we=%0b ill=%0b res=%0d required 1 0 16", rf_we, illegal, alu_res);
    end
    tick();
    exp_ret = exp_ret + 1'b1;
    tests_run++;
    if (rf_m[3] !== 32'd16 || retired !== exp_ret) begin
      tests_failed++;
      $display("FAIL ham_commit: r3=%0d ret=%0d required 16 %0d", rf_m[3], retired, exp_ret);
    end
`else
    tests_run++;
    if (alu_funct !== 4'd0) begin
      tests_failed++;
      $display("FAIL ham_off_exec: fn=%0d required 0", alu_funct);
    end
    tick();
    tests_run++;
    if ({rf_we, illegal} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ham_off_wb: we=%0b ill=%0b required 0 1", rf_we, illegal);
    end
    tick();
    tests_run++;
    if (rf_m[3] !== 32'h55 || retired !== exp_ret) begin
      tests_failed++;
      $display("FAIL ham_off_commit: r3=%h ret=%0d required 55 %0d", rf_m[3], retired, exp_ret);
    end
`endif
  endtask

  task automatic test_retire_wrap();
    preload(5'd1, 32'd7); preload(5'd2, 32'd5); preload(5'd7, 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive_accept(32'h00223801);
      tick();
      tick();
      exp_ret = exp_ret + 1'b1;
      tests_run++;
      if (retired !== exp_ret || rf_m[7] !== 32'd12) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: ret=%0d r7=%0d required %0d 12", i, retired, rf_m[7], exp_ret);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_ret      = '0;
    rst_n        = 1'b0;
    instr        = 32'd0;
    instr_valid  = 1'b0;
    pre_we       = 1'b0;
    pre_addr     = 5'd0;
    pre_data     = 32'd0;
    tick();
    test_reset();
    test_reset_mid_exec();
    test_add();
    test_sla();
    test_addi();
    test_back_to_back();
    test_rd_zero();
    test_illegal();
    test_ham();
    test_retire_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle instruction sequencer that drives the registered ALU: it accepts 32-bit instructions over a valid/ready handshake and decodes them into ALU function, shift-amount, operand-select and register-file addresses. It sequences the one-cycle ALU capture latency and issues the register-file write-back. It sits between instruction fetch and the datapath (register file and ALU) and is the initiator side of the ALU's `funct`/`shamt`/`res` interface.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock shared with the ALU and register file.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `rf_ra`  out  5  register-file read address A; feeds ALU `a`.
- `rf_rb`  out  5  register-file read address B; feeds ALU `b` when `b_sel`=0.
- `b_sel`  out  1  0 selects register B; 1 selects `imm` for ALU `b`.
- `imm`  out  32  sign-extended instr[15:0].
- `alu_funct`  out  4  ALU function code.
- `alu_shamt`  out  5  ALU shift amount.
- `rf_wa`  out  5  write-back address.
- `rf_we`  out  1  write-back enable; the write takes ALU `res`.
- `illegal`  out  1  one-cycle pulse for an undecodable instruction.
- `retired`  out  RETIRE_W  count of retired legal instructions.

## Operation
- ALU codes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 NOT (operates on `b`), 8 SLA, 9 SRL, 10 SRA, 11 INC, 12 DEC, 13 SLT, 14 SGT, 15 HAM. Code 0 makes the ALU hold `res`.
- Opcode 0x00 (R-type):
  - `alu_funct` = funct[3:0].
  - Legal only if funct[5:4]=0 and funct[3:0]≠0.
  - Destination is rd; `b_sel`=0.
- Opcode 0x01 (ADDI):
  - `alu_funct`=1, `b_sel`=1, destination is rt.
  - `alu_shamt`=0.
- Any other opcode is illegal.
- States:
  - IDLE: `instr_ready`=1. On handshake, latch decoded fields and go to EXEC.
  - EXEC: drive `alu_funct`, `alu_shamt`, `rf_ra`, `rf_rb`, `b_sel`, `imm`. The ALU captures the result at the end of EXEC. Go to WB.
  - WB: `rf_we`=1 if the instruction is legal and destination ≠ 0. `instr_ready`=1. On handshake, go to EXEC; otherwise go to IDLE.
- Illegal instruction:
  - EXEC drives `alu_funct`=0, so the ALU holds its result.
  - WB drives `rf_we`=0 and `illegal`=1; `retired` is not incremented.
- `retired` increments in WB for every legal instruction, including rd=0 writes that are suppressed. It wraps modulo 2^RETIRE_W.

## Timing
- Reset (asynchronous, any state): state IDLE, all outputs 0 except `instr_ready`=1; `retired`=0. An in-flight instruction is discarded and no write occurs.
- Accept on edge t; EXEC is cycle t+1; WB is cycle t+2 (`rf_we`, `illegal` valid).
- Back-to-back throughput is one instruction per 2 cycles. The next instruction's EXEC follows WB directly.
- Read-after-write is safe: the WB write commits at the WB edge, before the next EXEC read.
- Outside EXEC: `alu_funct`=0, `alu_shamt`=0, `b_sel`=0.
- Outside WB: `rf_we`=0, `illegal`=0.
- `rf_ra`, `rf_rb`, `rf_wa` and `imm` hold their latched values until the next accept.
- `instr_ready` is a function of state only; it never depends combinationally on `instr_valid`.

## Configuration
- `ALU_SEQ_CTRL_HAM_EN` defined: R-type funct 15 (HAM) is legal and issues `alu_funct`=15.
- Not defined: funct 15 is illegal and handled as any illegal instruction (ALU hold, no write, `illegal` pulse).

## Test plan
- Reset mid-EXEC: assert `rst_n`=0 during EXEC of 0x00221801 -> `rf_we` never asserts, state IDLE, `retired`=0.
- 0x00221801 (ADD r3=r1+r2, r1=7, r2=5) -> EXEC `alu_funct`=1; WB `rf_we`=1, `rf_wa`=3, written value 12; `retired`=1.
- 0x00A03108 (SLA r6=r5<<4, r5=3) -> EXEC `alu_funct`=8, `alu_shamt`=4; WB writes 48 to r6.
- 0x0424FFFC (ADDI r4=r1+(-4), r1=10) -> `b_sel`=1, `imm`=0xFFFFFFFC; WB writes 6 to r4.
- Back-to-back 0x00221801 then 0x00641802 with `instr_valid` held high -> accepts 2 cycles apart; the second EXEC reads the freshly written r3.
- 0x0022180F with r1=0xF0F0F0F0:
  - with `ALU_SEQ_CTRL_HAM_EN`: writes 16 to r3.
  - without it: `illegal` pulses in WB, `rf_we`=0, `retired` unchanged.
